apb_req_queue: RTL
==================

# apb_req_queue

Request queue and issue sequencer upstream of the APB master wrapper. Buffers host read/write requests in a DEPTH-entry FIFO and presents them one at a time on the wrapper's external-system inputs (transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT). It holds each request stable until the master reports completion, then returns read data and slave-error status to the host.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- PCLK  in  1  clock; all logic on the rising edge
- PRESET  in  1  reset; synchronous, active-high
- host_valid  in  1  host request present
- host_ready  out  1  queue can accept; equals !full, and 0 while PRESET is high
- host_write  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  request address
- host_wdata  in  DATA_W  write data
- host_strb  in  DATA_W/8  write byte strobes
- host_prot  in  3  protection attributes
- transfer  out  1  request active toward the master
- SWRITE, SADDR, SWDATA, SSTRB, SPROT  out  1/ADDR_W/DATA_W/DATA_W/8/3  current request fields
- m_done  in  1  one-cycle pulse from the master: access phase completed (PENABLE&PREADY)
- m_slverr  in  1  PSLVERR, qualified by m_done
- PRDATA  in  DATA_W  read data from the master, qualified by m_done
- rd_valid  out  1  one-cycle pulse: read completed
- rd_data  out  DATA_W  captured PRDATA
- resp_err  out  1  one-cycle pulse: completed access had PSLVERR
- err_cnt  out  8  saturating count of errored accesses
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO: write and read pointers wrap modulo DEPTH. Push when host_valid && host_ready. Pop only on m_done in BUSY. Occupancy range is 0..DEPTH.
- Stored entry: {write, addr, wdata, strb, prot}. For reads, strb is forced to 0 at push.
- FSM with two states, IDLE and BUSY:
  - IDLE, count≠0: load the head into the output registers, set transfer=1, go to BUSY.
  - IDLE, m_done: ignored. No pop, no response.
  - BUSY: output registers hold steady. On m_done: pop the head, set resp_err=m_slverr, and increment err_cnt (saturating at 255) if m_slverr. For a read, rd_data←PRDATA and rd_valid=1. For a write, rd_data holds its value.
  - BUSY, m_done with entries remaining after the pop: load the next head on the same edge, keep transfer=1, stay in BUSY (back-to-back).
  - BUSY, m_done with no entries remaining: transfer=0, go to IDLE. The output fields keep their last values.
- Push and pop on the same edge: legal. Occupancy is unchanged, and the pushed entry is never the one loaded on that edge.
- Full: host_ready=0, so host_valid is ignored. No overwrite.
- Reset, including mid-operation: FIFO flushed, pointers and count cleared, state=IDLE. An in-flight request is abandoned with no response.

## Timing
- Reset values: transfer=0, SWRITE=0, SADDR=0, SWDATA=0, SSTRB=0, SPROT=0, rd_valid=0, rd_data=0, resp_err=0, err_cnt=0, count=0, host_ready=0.
- Push into an empty idle queue at edge N: count=1 after N; transfer=1 with the fields valid after N+1.
- m_done at edge M: rd_valid/resp_err are high for exactly the cycle after M. On a back-to-back, the new fields are visible after M.
- Output fields change only on an IDLE→BUSY load or a back-to-back load. They never change while transfer=1 and m_done=0.
- host_ready is combinational from count and PRESET.

## Test plan
- Reset, then push write {addr 0x000000FF, wdata 0x01010101, strb 0xF}. Expect transfer=1 two edges later with those fields. Pulse m_done → transfer=0 next cycle, rd_valid stays 0, count=0.
- Push 4 writes back to back (0xFF, 0x1FF, 0x2FF, 0x3FF) with m_done held off. Expect count=4, host_ready=0, and a 5th push ignored. Then pulse m_done 4 times → transfer stays 1 throughout and SADDR steps 0xFF→0x1FF→0x2FF→0x3FF in order.
- Read of 0x2FF with host_strb=0x9. Expect SSTRB=0 and SWRITE=0. Pulse m_done with PRDATA=0x880000BB → rd_valid pulse, rd_data=0x880000BB.
- Read of 0x33 completing with m_slverr=1 → resp_err pulse and err_cnt=1. Repeat 300 errored accesses → err_cnt saturates at 255.
- With count=2 and BUSY, push and pop on the same edge → count stays 2, and the next load is the older entry.
- Assert PRESET for one cycle while BUSY with count=3. Expect transfer=0, count=0, and host_ready=0 during reset, 1 after. A stray m_done in IDLE → no pop and no rd_valid.

Source files
------------

// File: rtl/apb_req_queue.sv
// rtl/apb_req_queue.sv - request FIFO and issue sequencer feeding the APB master wrapper
// Holds each queued request on the S* outputs from load until m_done, then returns read data and error status.
module apb_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_write,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_wdata,
  input  logic [DATA_W/8-1:0]    host_strb,
  input  logic [2:0]             host_prot,
  output logic                   transfer,
  output logic                   SWRITE,
  output logic [ADDR_W-1:0]      SADDR,
  output logic [DATA_W-1:0]      SWDATA,
  output logic [DATA_W/8-1:0]    SSTRB,
  output logic [2:0]             SPROT,
  input  logic                   m_done,
  input  logic                   m_slverr,
  input  logic [DATA_W-1:0]      PRDATA,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   resp_err,
  output logic [7:0]             err_cnt,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;
  localparam int ENT_W = 1 + ADDR_W + DATA_W + STRB_W + 3;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT = (PTR_W + 1)'(1);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic             push, pop, load;
  logic [ENT_W-1:0] load_ent, push_ent;

  assign host_ready = !PRESET && (count != FULL_CNT);
  assign push = host_valid && host_ready;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign push_ent = {host_write, host_addr, host_wdata,
                     host_write ? host_strb : STRB_W'(0), host_prot};

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    load_ent  = mem[rd_ptr];
    case (state)
      IDLE: begin
        if (count != '0) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (m_done) begin
          pop = 1'b1;
          // An entry pushed on this edge is not counted yet, so it never gets loaded here.
          if (count > ONE_CNT) begin
            load     = 1'b1;
            load_ent = mem[rd_ptr_inc];
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      transfer <= 1'b0;
      SWRITE   <= 1'b0;
      SADDR    <= '0;
      SWDATA   <= '0;
      SSTRB    <= '0;
      SPROT    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      resp_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      rd_valid <= pop && !SWRITE;
      resp_err <= pop && m_slverr;
      if (pop && !SWRITE) rd_data <= PRDATA;
      if (pop && m_slverr && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (load) {SWRITE, SADDR, SWDATA, SSTRB, SPROT} <= load_ent;
      transfer <= (state_nxt == BUSY);
    end
  end
endmodule
